supercar_ctrl: RTL and testbench
================================

Name: supercar_ctrl

Overview:
- Sequencing controller for the board's bouncing "supercar" light bar on LEDR[9:0].
- Turns one-cycle command pulses into step strobes, direction and position for the light bar. Pulses come from the existing edge-triggered KEY inputs.
- Holds a run/pause state machine, a 4-level speed selector and a two-digit BCD sweep counter for the HEX displays.
- Sits between the key edge triggers and the bouncing shift register / BCD-to-7-segment decoders.

Parameters:
BASE_DIV, 2_500_000, CLOCK_50 cycles per base tick (50 ms); set to 4 in simulation
POS_MAX, 9, highest light position (LEDR index)
SWEEP_LIMIT, 10, sweeps before auto-stop (used only with SWEEP_LIMIT_EN)

Ports:
CLOCK_50     in   1  system clock, 50 MHz
reset        in   1  asynchronous, active-high
cmd_run      in   1  one-cycle pulse: start/pause toggle
cmd_faster   in   1  one-cycle pulse: speed +1
cmd_slower   in   1  one-cycle pulse: speed -1
step         out  1  one-cycle strobe, asserted in the cycle pos/dir take new values
dir          out  1  0 = moving toward POS_MAX, 1 = moving toward 0
pos          out  4  current lit position, 0..POS_MAX
speed        out  2  speed level, 0 slowest .. 3 fastest
running      out  1  1 while in RUN
sweeps_bcd   out  8  completed round trips, two BCD digits {tens, units}

Behaviour:
- Reset: the asynchronous reset forces all outputs to 0 (step 0, dir 0, pos 0, speed 0, running 0, sweeps_bcd 8'h00); state IDLE; timer 0.
- States: IDLE, RUN, PAUSE.
  - IDLE + cmd_run -> RUN. sweeps_bcd cleared to 00 in the same edge; pos stays 0, dir stays 0.
  - RUN + cmd_run -> PAUSE. pos, dir and sweeps are held.
  - PAUSE + cmd_run -> RUN. Resumes from the held pos/dir.
  - running = (state == RUN), registered: high the cycle after the cmd_run edge.
- Step period = BASE_DIV * 2^(3-speed) cycles: speed 0 = 8 ticks, 3 = 1 tick.
  - The timer clears on every entry to RUN and on every speed change.
  - The first step occurs a full period after entry; no step is issued in IDLE or PAUSE.
- Step rule:
  - dir 0 and pos < POS_MAX: pos+1. If pos reaches POS_MAX, dir becomes 1 on the same edge.
  - dir 1 and pos > 0: pos-1. If pos reaches 0, dir becomes 0 on the same edge and sweeps_bcd increments.
  - A round trip is 2*POS_MAX = 18 steps.
- sweeps_bcd is a BCD increment: units 9 -> 0 with tens+1; 99 -> 00 wraps.
- Speed:
  - cmd_faster: +1, saturates at 3. cmd_slower: -1, saturates at 0.
  - Both asserted in the same cycle: no change and no timer clear.
  - Accepted in every state.
- Simultaneous cmd_run and a speed command: both are applied in the same edge.
- cmd_run coincident with a step: the state change wins and no step is issued.
- Reset mid-operation: immediate return to the reset values; any pending step is discarded.

Optional Feature:
- Macro SUPERCAR_SWEEP_LIMIT_EN.
- Defined: on the step that increments sweeps_bcd to the BCD value of SWEEP_LIMIT, the state goes RUN -> IDLE on the same edge.
  - pos = 0, dir = 0; sweeps_bcd holds the limit value.
  - The next cmd_run clears the count and restarts.
- Undefined: sweeps_bcd free-runs modulo 100; RUN only exits via cmd_run or reset.

Decomposition:
- Package supercar_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2)
  - SPEED_MIN=0, SPEED_MAX=3
  - POS width = 4
  - the BCD digit width
- One sub-module, step_timer.
  - Inputs: CLOCK_50, reset, en, clr, speed.
  - Output: tick, a one-cycle pulse every BASE_DIV * 2^(3-speed) cycles while en is high.
  - Counter clears on clr.
- FSM, position/direction logic and the BCD sweep counter stay in supercar_ctrl.

Test Plan:
1. Reset released, no commands for 200 cycles -> step never asserted; pos 0, speed 0, running 0, sweeps_bcd 00.
2. BASE_DIV=4, 3x cmd_faster then cmd_run -> speed 3, running 1 next cycle; first step 4 cycles after running rises.
   - pos 0..9 then back to 0 over 18 steps; dir 1 from the pos=9 step; sweeps_bcd 01 at pos=0.
3. Speed saturation: 5x cmd_faster -> speed 3; 5x cmd_slower -> speed 0. cmd_faster and cmd_slower in the same cycle at speed 2 -> speed stays 2.
4. Pause at pos 5, dir 1, wait 100 cycles -> no step, outputs held. Second cmd_run -> next step gives pos 4.
5. Run 100 round trips at speed 3 -> sweeps_bcd passes 09 -> 10 and 99 -> 00. Assert reset mid-sweep -> all outputs return to reset values asynchronously.
6. With SUPERCAR_SWEEP_LIMIT_EN and SWEEP_LIMIT=3 -> after the 3rd round trip: running 0, sweeps_bcd 03, pos 0. Next cmd_run -> sweeps_bcd 00 and running 1.

Source files
------------

// File: rtl/supercar_pkg.sv
// Shared types, constants and BCD helpers for the supercar light-bar controller.
package supercar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] SPEED_MIN = 2'd0;
  localparam logic [1:0] SPEED_MAX = 2'd3;
  localparam int         POS_W     = 4;
  localparam int         BCD_W     = 4;

  typedef logic [2*BCD_W-1:0] bcd2_t;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    logic [BCD_W-1:0] units;
    logic [BCD_W-1:0] tens;
    units = v[BCD_W-1:0];
    tens  = v[2*BCD_W-1:BCD_W];
    if (units == BCD_W'(9)) begin
      units = '0;
      tens  = (tens == BCD_W'(9)) ? '0 : tens + 1'b1;
    end else begin
      units = units + 1'b1;
    end
    return {tens, units};
  endfunction

  function automatic bcd2_t to_bcd(input int n);
    return {BCD_W'((n / 10) % 10), BCD_W'(n % 10)};
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step-period timer: one-cycle tick every BASE_DIV * 2^(3-speed) enabled cycles.
module step_timer
  import supercar_pkg::*;
#(
  parameter int BASE_DIV = 2_500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int CNT_W = $clog2(BASE_DIV << 3);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] last;

  assign last = CNT_W'((BASE_DIV << (SPEED_MAX - speed)) - 1);
  // >= keeps the timer safe should the period ever shrink below the count.
  assign tick = en && (cnt_q >= last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/supercar_ctrl.sv
// Run/pause FSM, speed selector, bouncing position and BCD sweep counter for LEDR[9:0].
// Optional: define SUPERCAR_SWEEP_LIMIT_EN to stop automatically after SWEEP_LIMIT round trips.
module supercar_ctrl
  import supercar_pkg::*;
#(
  parameter int BASE_DIV    = 2_500_000,
  parameter int POS_MAX     = 9,
  parameter int SWEEP_LIMIT = 10
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             cmd_run,
  input  logic             cmd_faster,
  input  logic             cmd_slower,
  output logic             step,
  output logic             dir,
  output logic [POS_W-1:0] pos,
  output logic [1:0]       speed,
  output logic             running,
  output logic [7:0]       sweeps_bcd
);

`ifdef SUPERCAR_SWEEP_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam bcd2_t            LIMIT_BCD = to_bcd(SWEEP_LIMIT);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(POS_MAX);

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [1:0]       speed_q, speed_d;
  bcd2_t            sweeps_q, sweeps_d;
  logic             step_q, step_d;
  logic             running_q, running_d;
  logic             timer_clr;
  logic             tick;

  step_timer #(
    .BASE_DIV(BASE_DIV)
  ) u_step_timer (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .en      (state_q == RUN),
    .clr     (timer_clr),
    .speed   (speed_q),
    .tick    (tick)
  );

  always_comb begin
    // NOTE: every signal is given a default first, so no path can infer a latch.
    state_d   = state_q;
    pos_d     = pos_q;
    dir_d     = dir_q;
    speed_d   = speed_q;
    sweeps_d  = sweeps_q;
    step_d    = 1'b0;
    timer_clr = 1'b0;

    // Opposing speed commands in one cycle cancel out, timer untouched.
    if (cmd_faster && !cmd_slower && speed_q != SPEED_MAX) begin
      speed_d   = speed_q + 2'd1;
      timer_clr = 1'b1;
    end else if (cmd_slower && !cmd_faster && speed_q != SPEED_MIN) begin
      speed_d   = speed_q - 2'd1;
      timer_clr = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_run) begin
          state_d   = RUN;
          sweeps_d  = '0;
          timer_clr = 1'b1;
        end
      end
      RUN: begin
        // A run/pause command outranks a coincident tick.
        if (cmd_run) begin
          state_d = PAUSE;
        end else if (tick) begin
          step_d = 1'b1;
          if (!dir_q) begin
            if (pos_q < POS_LAST) begin
              pos_d = pos_q + 1'b1;
              if (pos_d == POS_LAST) dir_d = 1'b1;
            end
          end else if (pos_q != '0) begin
            pos_d = pos_q - 1'b1;
            if (pos_d == '0) begin
              dir_d    = 1'b0;
              sweeps_d = bcd_inc(sweeps_q);
              if (LIMIT_EN && sweeps_d == LIMIT_BCD) state_d = IDLE;
            end
          end
        end
      end
      PAUSE: begin
        if (cmd_run) begin
          state_d   = RUN;
          timer_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    running_d = (state_d == RUN);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      dir_q     <= 1'b0;
      speed_q   <= SPEED_MIN;
      sweeps_q  <= '0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_q     <= dir_d;
      speed_q   <= speed_d;
      sweeps_q  <= sweeps_d;
      step_q    <= step_d;
      running_q <= running_d;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign pos        = pos_q;
  assign speed      = speed_q;
  assign running    = running_q;
  assign sweeps_bcd = sweeps_q;

endmodule

// File: tb/tb_supercar_ctrl.sv
// Self-checking bench for supercar_ctrl: speed command table plus a step scoreboard.
module tb_supercar_ctrl;

`ifdef SUPERCAR_SWEEP_LIMIT_EN
  localparam int TB_LIMIT = 3;
`else
  localparam int TB_LIMIT = 10;
`endif
  localparam int TB_POS_MAX = 9;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_run = 1'b0;
  logic       cmd_faster = 1'b0;
  logic       cmd_slower = 1'b0;
  logic       step;
  logic       dir;
  logic [3:0] pos;
  logic [1:0] speed;
  logic       running;
  logic [7:0] sweeps_bcd;

  supercar_ctrl #(
    .BASE_DIV   (4),
    .POS_MAX    (TB_POS_MAX),
    .SWEEP_LIMIT(TB_LIMIT)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .cmd_run   (cmd_run),
    .cmd_faster(cmd_faster),
    .cmd_slower(cmd_slower),
    .step      (step),
    .dir       (dir),
    .pos       (pos),
    .speed     (speed),
    .running   (running),
    .sweeps_bcd(sweeps_bcd)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [3:0] pos;
    logic       dir;
    logic [7:0] sweeps;
  } exp_step_t;

  typedef struct {
    logic       faster;
    logic       slower;
    logic [1:0] exp_speed;
    logic       exp_running;
  } vec_t;

  int        n_checks = 0;
  int        n_pass = 0;
  exp_step_t sb_q[$];
  vec_t      vecs[14];

  // Reference walk: integer position and round-trip count.
  int m_pos = 0;
  bit m_dir = 1'b0;
  int m_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] bcd_of(input int n);
    return {4'((n % 100) / 10), 4'(n % 10)};
  endfunction

  function automatic void model_push();
    exp_step_t e;
    if (!m_dir) begin
      m_pos++;
      if (m_pos == TB_POS_MAX) m_dir = 1'b1;
    end else begin
      m_pos--;
      if (m_pos == 0) begin
        m_dir = 1'b0;
        m_cnt++;
      end
    end
    e.pos    = 4'(m_pos);
    e.dir    = m_dir;
    e.sweeps = bcd_of(m_cnt);
    sb_q.push_back(e);
  endfunction

  // Every step strobe is matched against the next expected step.
  always @(negedge CLOCK_50) begin : step_monitor
    exp_step_t e;
    if (!reset && step) begin
      if (sb_q.size() == 0) begin
        check("unexpected_step", 32'(step), 0);
      end else begin
        e = sb_q.pop_front();
        check("step_pos", 32'(pos), 32'(e.pos));
        check("step_dir", 32'(dir), 32'(e.dir));
        check("step_sweeps", 32'(sweeps_bcd), 32'(e.sweeps));
      end
    end
  end

  task automatic pulse(input logic r, input logic f, input logic s);
    @(negedge CLOCK_50);
    cmd_run    = r;
    cmd_faster = f;
    cmd_slower = s;
    @(negedge CLOCK_50);
    cmd_run    = 1'b0;
    cmd_faster = 1'b0;
    cmd_slower = 1'b0;
  endtask

  task automatic run_measure(input logic f, input int exp_lat, input string name);
    int lat = 0;
    pulse(1'b1, f, 1'b0);
    check({name, "_running"}, 32'(running), 1);
    while (lat < 200) begin
      lat++;
      @(negedge CLOCK_50);
      if (step) break;
    end
    check(name, 32'(lat), 32'(exp_lat));
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge CLOCK_50);
      #1;
      n++;
    end
    check(name, 32'(sb_q.size()), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_step"}, 32'(step), 0);
    check({tag, "_dir"}, 32'(dir), 0);
    check({tag, "_pos"}, 32'(pos), 0);
    check({tag, "_speed"}, 32'(speed), 0);
    check({tag, "_running"}, 32'(running), 0);
    check({tag, "_sweeps"}, 32'(sweeps_bcd), 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'd1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd3, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd3, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'd3, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 2'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'd1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 2'd2, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 2'd3, 1'b0};

    // Reset and idle
    repeat (3) @(negedge CLOCK_50);
    check_reset_vals("in_reset");
    reset = 1'b0;
    repeat (200) @(negedge CLOCK_50);
    check_reset_vals("idle200");

    // Speed commands in IDLE, including saturation and cancelling pair
    for (int i = 0; i < 14; i++) begin
      pulse(1'b0, vecs[i].faster, vecs[i].slower);
      check($sformatf("vec%0d_speed", i), 32'(speed), 32'(vecs[i].exp_speed));
      check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_running));
    end

    // One full round trip at speed 3
    repeat (18) model_push();
    run_measure(1'b0, 4, "lat_first");
    drain(200, "drain_trip");
    check("trip_sweeps", 32'(sweeps_bcd), 32'h01);
    check("trip_pos", 32'(pos), 0);
    pulse(1'b1, 1'b0, 1'b0);
    check("pause_running", 32'(running), 0);

    // Pause at pos 5 heading down, hold, then resume
    repeat (13) model_push();
    run_measure(1'b0, 4, "lat_resume");
    drain(200, "drain_to5");
    pulse(1'b1, 1'b0, 1'b0);
    repeat (100) @(negedge CLOCK_50);
    check("hold_pos", 32'(pos), 5);
    check("hold_dir", 32'(dir), 1);
    check("hold_sweeps", 32'(sweeps_bcd), 32'h01);
    check("hold_running", 32'(running), 0);
    model_push();
    pulse(1'b1, 1'b0, 1'b0);
    drain(50, "drain_resume");
    check("resume_pos", 32'(pos), 4);
    pulse(1'b1, 1'b0, 1'b0);

    // Slowest period, then run combined with faster on the same edge
    repeat (3) pulse(1'b0, 1'b0, 1'b1);
    check("speed0", 32'(speed), 0);
    model_push();
    run_measure(1'b0, 32, "lat_speed0");
    drain(50, "drain_speed0");
    pulse(1'b1, 1'b0, 1'b0);
    model_push();
    run_measure(1'b1, 16, "lat_run_faster");
    check("run_faster_speed", 32'(speed), 1);
    drain(50, "drain_speed1");
    pulse(1'b1, 1'b0, 1'b0);
    repeat (2) pulse(1'b0, 1'b1, 1'b0);
    check("speed3_again", 32'(speed), 3);

`ifndef SUPERCAR_SWEEP_LIMIT_EN
    // 100 round trips: BCD passes 09->10 and 99->00
    repeat (1800) model_push();
    pulse(1'b1, 1'b0, 1'b0);
    drain(1800 * 4 + 100, "drain_long");
    check("long_sweeps", 32'(sweeps_bcd), 32'h01);
    check("long_pos", 32'(pos), 2);
    check("long_running", 32'(running), 1);
`else
    // Auto-stop on reaching the sweep limit, then restart clears the count
    while (m_cnt < TB_LIMIT) model_push();
    pulse(1'b1, 1'b0, 1'b0);
    drain(400, "drain_limit");
    repeat (3) @(negedge CLOCK_50);
    check("limit_running", 32'(running), 0);
    check("limit_sweeps", 32'(sweeps_bcd), 32'h03);
    check("limit_pos", 32'(pos), 0);
    check("limit_dir", 32'(dir), 0);
    repeat (50) @(negedge CLOCK_50);
    m_cnt = 0;
    pulse(1'b1, 1'b0, 1'b0);
    check("restart_sweeps", 32'(sweeps_bcd), 0);
    check("restart_running", 32'(running), 1);
`endif

    // Asynchronous reset mid-operation, well clear of any clock edge
    @(posedge CLOCK_50);
    #3 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    sb_q.delete();
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (40) @(negedge CLOCK_50);
    check_reset_vals("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
